// File: rtl/ce_avg_seq_if.sv
// Pilot-memory read port plus averager control bundle for the CE averaging sequencer.
interface ce_avg_seq_if #(
    parameter int AW = 3
);
    logic          mem_req;
    logic          mem_gnt;
    logic          rd_en;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic          avg_en;
    logic [1:0]    avg_wr_addr;
    logic [2:0]    v_shift;

    modport master (
        output mem_req, rd_en, rd_addr_a, rd_addr_b, avg_en, avg_wr_addr, v_shift,
        input  mem_gnt
    );

    modport slave (
        input  mem_req, rd_en, rd_addr_a, rd_addr_b, avg_en, avg_wr_addr, v_shift,
        output mem_gnt
    );
endinterface

// File: rtl/ce_avg_seq.sv
// Channel-estimation averaging sequencer: fetches four pilot pairs (k, k+4) and
// steers the real/imag averagers through a RD_LAT-deep valid/slot pipe.
module ce_avg_seq #(
    parameter int RD_LAT = 1,
    parameter int AW     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] v_shift_in,
    ce_avg_seq_if.master bus,
    output logic       busy,
    output logic       done,
    output logic       cfg_err
);
    typedef enum logic [2:0] {IDLE, REQ, READ, DRAIN, DONE} state_t;

    state_t                  state, state_nx;
    logic [1:0]              k, wcnt;
    logic [2:0]              vsh;
    logic [RD_LAT:1]         vld_pipe;
    logic [RD_LAT:1][1:0]    k_pipe;
    logic                    kill, accept, reject, rd, wr;

    // Abort only acts on a running pass and always beats a same-cycle start.
    assign kill   = abort && (state != IDLE);
    assign accept = (state == IDLE) && start && !abort && (v_shift_in <= 3'd5);
    assign reject = (state == IDLE) && start && !abort && (v_shift_in >  3'd5);
    assign rd     = (state == READ) && bus.mem_gnt;
    assign wr     = vld_pipe[RD_LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = REQ;
            REQ:   if (kill) state_nx = IDLE;
                   else if (bus.mem_gnt) state_nx = READ;
            READ:  if (kill) state_nx = IDLE;
                   else if (rd && k == 2'd3) state_nx = DRAIN;
            DRAIN: if (kill) state_nx = IDLE;
                   else if (wr && wcnt == 2'd3) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_req     = (state == REQ) || (state == READ);
        bus.rd_en       = rd;
        bus.rd_addr_a   = rd ? AW'(k) : '0;
        bus.rd_addr_b   = rd ? AW'({1'b1, k}) : '0;
        bus.avg_en      = wr;
        bus.avg_wr_addr = wr ? k_pipe[RD_LAT] : 2'd0;
        bus.v_shift     = vsh;
        busy            = (state != IDLE);
        done            = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k        <= '0;
            wcnt     <= '0;
            vsh      <= '0;
            cfg_err  <= 1'b0;
            vld_pipe <= '0;
            k_pipe   <= '0;
        end else begin
            cfg_err <= reject;
            if (accept) vsh <= v_shift_in;
            if (accept || kill) k <= '0;
            else if (rd)        k <= k + 2'd1;
            if (accept || kill) wcnt <= '0;
            else if (wr)        wcnt <= wcnt + 2'd1;
            // Flushing the pipe on abort guarantees no stray averager writes.
            if (kill) begin
                vld_pipe <= '0;
            end else begin
                vld_pipe[1] <= rd;
                k_pipe[1]   <= k;
                for (int i = 2; i <= RD_LAT; i++) begin
                    vld_pipe[i] <= vld_pipe[i-1];
                    k_pipe[i]   <= k_pipe[i-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_ce_avg_seq.sv
// Directed bench for ce_avg_seq: three instances at RD_LAT 1, 2, 3 share control inputs.
module tb_ce_avg_seq;
    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
    logic [2:0] v_shift_in = 3'd0;
    logic       busy1, done1, cfg1, busy2, done2, cfg2, busy3, done3, cfg3;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    ce_avg_seq_if #(.AW(3)) b1 ();
    ce_avg_seq_if #(.AW(3)) b2 ();
    ce_avg_seq_if #(.AW(3)) b3 ();

    ce_avg_seq #(.RD_LAT(1), .AW(3)) u1 (.clk(clk), .rst(rst), .start(start), .abort(abort),
        .v_shift_in(v_shift_in), .bus(b1.master), .busy(busy1), .done(done1), .cfg_err(cfg1));
    ce_avg_seq #(.RD_LAT(2), .AW(3)) u2 (.clk(clk), .rst(rst), .start(start), .abort(abort),
        .v_shift_in(v_shift_in), .bus(b2.master), .busy(busy2), .done(done2), .cfg_err(cfg2));
    ce_avg_seq #(.RD_LAT(3), .AW(3)) u3 (.clk(clk), .rst(rst), .start(start), .abort(abort),
        .v_shift_in(v_shift_in), .bus(b3.master), .busy(busy3), .done(done3), .cfg_err(cfg3));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({b1.mem_req, b1.rd_en, b1.rd_addr_a, b1.rd_addr_b, b1.avg_en, b1.avg_wr_addr,
             b1.v_shift, busy1, done1, cfg1} !== 17'd0) begin
            errors++; $display("FAIL reset_u1 got nonzero outputs busy=%0b mem_req=%0b", busy1, b1.mem_req);
        end
        checks++;
        if ({b2.mem_req, b2.rd_en, b2.avg_en, b2.v_shift, busy2, done2, cfg2} !== 9'd0) begin
            errors++; $display("FAIL reset_u2 got nonzero outputs busy=%0b", busy2);
        end
        checks++;
        if ({b3.mem_req, b3.rd_en, b3.avg_en, b3.v_shift, busy3, done3, cfg3} !== 9'd0) begin
            errors++; $display("FAIL reset_u3 got nonzero outputs busy=%0b", busy3);
        end
        cyc(); cyc();
        rst = 1'b1;
        cyc();
    endtask

    // RD_LAT=1, grant always high: reads 2..5, writes 3..6, done at 7.
    task automatic test_nominal();
        logic [6:0] xr;
        logic [2:0] xa, xc;
        cyc(); start = 1'b1; v_shift_in = 3'd4;
        for (int c = 1; c <= 9; c++) begin
            cyc(); start = 1'b0; #4;
            xr = (c >= 2 && c <= 5) ? {1'b1, 3'(c - 2), 3'(c + 2)} : 7'd0;
            xa = (c >= 3 && c <= 6) ? {1'b1, 2'(c - 3)} : 3'd0;
            xc = {(c >= 1 && c <= 5), (c >= 1 && c <= 7), (c == 7)};
            checks++;
            if ({b1.rd_en, b1.rd_addr_a, b1.rd_addr_b} !== xr) begin
                errors++; $display("FAIL nom_rd c%0d got %b exp %b", c, {b1.rd_en, b1.rd_addr_a, b1.rd_addr_b}, xr);
            end
            checks++;
            if ({b1.avg_en, b1.avg_wr_addr} !== xa) begin
                errors++; $display("FAIL nom_avg c%0d got %b exp %b", c, {b1.avg_en, b1.avg_wr_addr}, xa);
            end
            checks++;
            if ({b1.mem_req, busy1, done1} !== xc) begin
                errors++; $display("FAIL nom_ctrl c%0d got %b exp %b", c, {b1.mem_req, busy1, done1}, xc);
            end
            checks++;
            if (b1.v_shift !== 3'd4) begin
                errors++; $display("FAIL nom_vshift c%0d got %0d exp 4", c, b1.v_shift);
            end
        end
    endtask

    // RD_LAT=2, grant low in REQ (c1) and on the 2nd issue slot (c4).
    task automatic test_grant_stall();
        int ka [13] = '{-1, -1, -1, 0, -1, 1, 2, 3, -1, -1, -1, -1, -1};
        int wa [13] = '{-1, -1, -1, -1, -1, 0, -1, 1, 2, 3, -1, -1, -1};
        int nrd = 0;
        logic [6:0] xr;
        logic [2:0] xa, xc;
        cyc(); start = 1'b1; v_shift_in = 3'd5;
        for (int c = 1; c <= 12; c++) begin
            cyc(); start = 1'b0; b2.mem_gnt = (c != 1 && c != 4); #4;
            xr = (ka[c] >= 0) ? {1'b1, 3'(ka[c]), 3'(ka[c] + 4)} : 7'd0;
            xa = (wa[c] >= 0) ? {1'b1, 2'(wa[c])} : 3'd0;
            xc = {(c >= 1 && c <= 7), (c >= 1 && c <= 10), (c == 10)};
            if (b2.rd_en) nrd++;
            checks++;
            if ({b2.rd_en, b2.rd_addr_a, b2.rd_addr_b} !== xr) begin
                errors++; $display("FAIL stall_rd c%0d got %b exp %b", c, {b2.rd_en, b2.rd_addr_a, b2.rd_addr_b}, xr);
            end
            checks++;
            if ({b2.avg_en, b2.avg_wr_addr} !== xa) begin
                errors++; $display("FAIL stall_avg c%0d got %b exp %b", c, {b2.avg_en, b2.avg_wr_addr}, xa);
            end
            checks++;
            if ({b2.mem_req, busy2, done2} !== xc) begin
                errors++; $display("FAIL stall_ctrl c%0d got %b exp %b", c, {b2.mem_req, busy2, done2}, xc);
            end
        end
        b2.mem_gnt = 1'b1;
        checks++;
        if (nrd != 4) begin
            errors++; $display("FAIL stall_rd_count got %0d exp 4", nrd);
        end
        checks++;
        if (b2.v_shift !== 3'd5) begin
            errors++; $display("FAIL stall_vshift got %0d exp 5", b2.v_shift);
        end
    endtask

    task automatic test_cfg_err();
        cyc(); start = 1'b1; v_shift_in = 3'd6;
        for (int c = 1; c <= 3; c++) begin
            cyc(); start = 1'b0; #4;
            checks++;
            if (cfg1 !== (c == 1)) begin
                errors++; $display("FAIL cfg_pulse c%0d got %0b exp %0b", c, cfg1, (c == 1));
            end
            checks++;
            if ({b1.mem_req, busy1, b1.rd_en} !== 3'b000) begin
                errors++; $display("FAIL cfg_idle c%0d got %b exp 000", c, {b1.mem_req, busy1, b1.rd_en});
            end
            checks++;
            if (b1.v_shift !== 3'd5) begin
                errors++; $display("FAIL cfg_vshift c%0d got %0d exp 5", c, b1.v_shift);
            end
        end
    endtask

    // RD_LAT=3: abort at c4 (after 2nd read), restart at c5, full pass from r=c-5.
    task automatic test_abort();
        int r, nav = 0, ndn = 0;
        logic xrd, xav, xreq, xbusy, xdone;
        cyc(); start = 1'b1; v_shift_in = 3'd2;
        for (int c = 1; c <= 16; c++) begin
            cyc(); start = (c == 5); abort = (c == 4); #4;
            r     = (c >= 6) ? c - 5 : c;
            xrd   = (c != 5) && r >= 2 && r <= 5;
            xav   = (c != 5) && r >= 5 && r <= 8;
            xreq  = (c != 5) && r >= 1 && r <= 5;
            xbusy = (c != 5) && r >= 1 && r <= 9;
            xdone = (c != 5) && r == 9;
            if (b3.avg_en) nav++;
            if (done3) ndn++;
            checks++;
            if ({b3.mem_req, b3.rd_en, b3.avg_en, busy3, done3} !== {xreq, xrd, xav, xbusy, xdone}) begin
                errors++; $display("FAIL abort_ctrl c%0d got %b exp %b", c,
                    {b3.mem_req, b3.rd_en, b3.avg_en, busy3, done3}, {xreq, xrd, xav, xbusy, xdone});
            end
            if (xrd) begin
                checks++;
                if ({b3.rd_addr_a, b3.rd_addr_b} !== {3'(r - 2), 3'(r + 2)}) begin
                    errors++; $display("FAIL abort_addr c%0d got %b exp %b", c, {b3.rd_addr_a, b3.rd_addr_b}, {3'(r - 2), 3'(r + 2)});
                end
            end
            if (xav) begin
                checks++;
                if (b3.avg_wr_addr !== 2'(r - 5)) begin
                    errors++; $display("FAIL abort_wr c%0d got %0d exp %0d", c, b3.avg_wr_addr, r - 5);
                end
            end
            checks++;
            if (b3.v_shift !== 3'd2) begin
                errors++; $display("FAIL abort_vshift c%0d got %0d exp 2", c, b3.v_shift);
            end
        end
        checks++;
        if (nav != 4 || ndn != 1) begin
            errors++; $display("FAIL abort_counts got avg=%0d done=%0d exp avg=4 done=1", nav, ndn);
        end
    endtask

    // RD_LAT=1: ignored starts at c2/c4, accepted restart at c8 right after done.
    task automatic test_back_to_back();
        int nav = 0;
        logic [2:0] xa;
        logic [1:0] xc;
        cyc(); start = 1'b1; v_shift_in = 3'd1;
        for (int c = 1; c <= 18; c++) begin
            cyc(); start = (c == 2 || c == 4 || c == 8); v_shift_in = (c == 8) ? 3'd0 : 3'd3; #4;
            xa = (c >= 3 && c <= 6)   ? {1'b1, 2'(c - 3)}  :
                 (c >= 11 && c <= 14) ? {1'b1, 2'(c - 11)} : 3'd0;
            xc = {((c >= 1 && c <= 7) || (c >= 9 && c <= 15)), (c == 7 || c == 15)};
            if (b1.avg_en) nav++;
            checks++;
            if ({b1.avg_en, b1.avg_wr_addr} !== xa) begin
                errors++; $display("FAIL b2b_avg c%0d got %b exp %b", c, {b1.avg_en, b1.avg_wr_addr}, xa);
            end
            checks++;
            if ({busy1, done1} !== xc) begin
                errors++; $display("FAIL b2b_ctrl c%0d got %b exp %b", c, {busy1, done1}, xc);
            end
            checks++;
            if (b1.v_shift !== ((c <= 8) ? 3'd1 : 3'd0)) begin
                errors++; $display("FAIL b2b_vshift c%0d got %0d exp %0d", c, b1.v_shift, (c <= 8) ? 1 : 0);
            end
        end
        checks++;
        if (nav != 8) begin
            errors++; $display("FAIL b2b_avg_count got %0d exp 8", nav);
        end
    endtask

    task automatic test_async_reset();
        logic [6:0] xr;
        logic [3:0] xa;
        cyc(); start = 1'b1; v_shift_in = 3'd3;
        cyc(); start = 1'b0;
        cyc(); cyc();
        #2; rst = 1'b0; #1;
        checks++;
        if ({b1.mem_req, b1.rd_en, b1.rd_addr_a, b1.rd_addr_b, b1.avg_en, b1.avg_wr_addr,
             b1.v_shift, busy1, done1, cfg1} !== 17'd0) begin
            errors++; $display("FAIL arst_outputs got busy=%0b rd_en=%0b v_shift=%0d exp all 0", busy1, b1.rd_en, b1.v_shift);
        end
        cyc(); cyc();
        rst = 1'b1;
        cyc(); start = 1'b1; v_shift_in = 3'd3;
        for (int c = 1; c <= 9; c++) begin
            cyc(); start = 1'b0; #4;
            xr = (c >= 2 && c <= 5) ? {1'b1, 3'(c - 2), 3'(c + 2)} : 7'd0;
            xa = (c >= 3 && c <= 6) ? {1'b1, 2'(c - 3), (c == 7)} : {3'd0, (c == 7)};
            checks++;
            if ({b1.rd_en, b1.rd_addr_a, b1.rd_addr_b} !== xr) begin
                errors++; $display("FAIL arst_rd c%0d got %b exp %b", c, {b1.rd_en, b1.rd_addr_a, b1.rd_addr_b}, xr);
            end
            checks++;
            if ({b1.avg_en, b1.avg_wr_addr, done1} !== xa) begin
                errors++; $display("FAIL arst_avg c%0d got %b exp %b", c, {b1.avg_en, b1.avg_wr_addr, done1}, xa);
            end
        end
    endtask

    initial begin
        b1.mem_gnt = 1'b1;
        b2.mem_gnt = 1'b1;
        b3.mem_gnt = 1'b1;
        test_reset();
        test_nominal();
        test_grant_stall();
        test_cfg_err();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
